debounce_scheduler: RTL and testbench
=====================================

# debounce_scheduler

Time-multiplexed debounce controller that shares one settle-timer between N switch/button inputs. It synchronizes every raw input and grants the single timer round-robin to any input whose level disagrees with its debounced value. It commits the new level only if the input held steady for the whole settle window, and emits a one-cycle press pulse per input. It sits between the board push-buttons/switches and the core/UART control logic, replacing one FSM-plus-delayer pair per input.

## Interface
- N, 4, number of inputs; legal range 2..16.
- DELAY_CYCLES, 10, settle window in clk cycles; legal value ≥1.
- IDX_W, $clog2(N), width of the index fields (derived; not overridden).
- clk  input  1  system clock; all state updates on the rising edge.
- nrst  input  1  reset; asynchronous, active-low; clears all state immediately.
- sw  input  N  raw asynchronous switch levels.
- stable  output  N  debounced levels, registered.
- one_shot  output  N  one-cycle pulse on a debounced 0→1 transition, registered.
- busy  output  1  high while the timer is granted to an input (state ≠ IDLE).
- active_idx  output  IDX_W  index of the input currently holding the timer; holds its last value in IDLE.

## Operation
- Synchronizer: two flops per bit, sw → s1 → s2; all decisions use s2. mismatch[i] = s2[i] ^ stable[i].
- Round-robin pointer ptr (IDX_W bits): the search order is ptr, ptr+1, … mod N.
- FSM states: IDLE, WAIT, CHECK.
- IDLE, no mismatch: stay in IDLE.
- IDLE, any mismatch: idx ← first mismatching index in search order, cnt ← 0, go to WAIT.
- WAIT, s2[idx] == stable[idx] (bounce back): abort to IDLE, no commit, no pulse, ptr ← idx+1 mod N.
- WAIT, cnt == DELAY_CYCLES-1: go to CHECK.
- WAIT, otherwise: cnt ← cnt+1.
- CHECK, s2[idx] ≠ stable[idx]: stable[idx] ← s2[idx]. If the new level is 1, one_shot[idx] ← 1 for exactly one cycle.
- CHECK, any outcome: go to IDLE; ptr ← idx+1 mod N.
- A debounced 1→0 transition updates stable and produces no pulse.
- Only stable[idx] may change. All other stable bits hold.
- At most one one_shot bit is high in any cycle. one_shot defaults to 0 every cycle.
- cnt width: $clog2(DELAY_CYCLES+1). cnt never wraps, because it is reloaded on every grant.
- Simultaneous changes on several inputs are served one at a time in round-robin order. A waiting input is granted within N-1 grants.
- Changes on non-granted inputs during a window are not lost. Their mismatch persists until they are served.

## Timing
- Reset values: s1 = s2 = 0, stable = 0, one_shot = 0, busy = 0, active_idx = 0, ptr = 0, cnt = 0, state IDLE.
- Reset asserted mid-window: immediate clear. No pulse is emitted, and no commit occurs after release.
- After reset release, an input that is held high is detected as a mismatch and debounced normally; its pulse follows the full latency.
- Latency, idle controller: the raw level is first sampled at edge E0 (by s1). stable[i] and one_shot[i] update at edge E0+DELAY_CYCLES+3, which is E0+13 with the defaults.
- one_shot stays high for exactly one cycle.
- busy rises at the edge entering WAIT (E0+2) and falls at the edge leaving CHECK.
- An input that is busy-blocked waits for the current grant to finish. Its earliest grant is the edge after CHECK→IDLE plus one IDLE cycle.
- Back-to-back grants: each grant occupies DELAY_CYCLES+2 cycles (WAIT + CHECK + IDLE).
- A glitch shorter than 2 cycles on s2 during WAIT aborts that grant. The input re-requests afterwards if the mismatch persists.

## Test plan
- Single press, N=4, DELAY_CYCLES=10: sw=4'b0001 held from E0 → stable=4'b0001 and one_shot=4'b0001 at edge E0+13 for one cycle; busy high from E0+2 to E0+12.
- Bounce: sw[2] toggles 1,0,1 every 3 cycles, then holds 1 → no pulse during the bouncing; exactly one one_shot[2] pulse, 13 cycles after the final rise at the latest; stable[2]=1.
- Release: with stable=4'b0001, set sw[0]=0 → stable[0]=0 after 13 cycles; one_shot stays 0 throughout.
- Simultaneous: sw 0→4'b1111 at E0 with ptr=0 → pulses on idx 0,1,2,3 in order, spaced 12 cycles apart; the first at E0+13; never two pulse bits high together.
- Fairness: after serving idx 2, set sw[1] and sw[3] together → idx 3 is served before idx 1.
- Reset mid-window: assert nrst=0 at cnt=5 → all outputs 0 asynchronously; no pulse; after release with sw held, one pulse 13 cycles later.

Source files
------------

// File: rtl/debounce_scheduler.sv
// Debounces N synchronized inputs with one settle timer granted round-robin to mismatching inputs.
// Latency: stable/one_shot update DELAY_CYCLES+3 edges after the raw level is first sampled.
// Backpressure: inputs waiting for the timer keep their mismatch and are served within N-1 grants.
module debounce_scheduler #(
    parameter  int N            = 4,
    parameter  int DELAY_CYCLES = 10,
    localparam int IDX_W        = $clog2(N)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N-1:0]     sw,
    output logic [N-1:0]     stable,
    output logic [N-1:0]     one_shot,
    output logic             busy,
    output logic [IDX_W-1:0] active_idx
);

    localparam int               CNT_W    = $clog2(DELAY_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     s1, s2;
    logic [N-1:0]     mismatch;
    logic [N-1:0]     stable_nxt, one_shot_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [IDX_W-1:0] ptr, ptr_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             req_vld;
    logic [IDX_W-1:0] req_idx;

    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] base, input int ofs);
        int sum;
        sum = int'(base) + ofs;
        if (sum >= N) begin
            sum = sum - N;
        end
        return IDX_W'(sum);
    endfunction

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    assign mismatch = s2 ^ stable;

    // Descending scan so the lowest offset from ptr wins the grant.
    always_comb begin
        req_vld = 1'b0;
        req_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mismatch[idx_add(ptr, k)]) begin
                req_vld = 1'b1;
                req_idx = idx_add(ptr, k);
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        ptr_nxt      = ptr;
        cnt_nxt      = cnt;
        stable_nxt   = stable;
        one_shot_nxt = '0;
        unique case (state)
            S_IDLE: begin
                if (req_vld) begin
                    idx_nxt   = req_idx;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!mismatch[idx]) begin
                    state_nxt = S_IDLE;
                    ptr_nxt   = idx_add(idx, 1);
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_CHECK;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_CHECK: begin
                if (mismatch[idx]) begin
                    stable_nxt[idx]   = s2[idx];
                    one_shot_nxt[idx] = s2[idx];
                end
                state_nxt = S_IDLE;
                ptr_nxt   = idx_add(idx, 1);
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= S_IDLE;
            idx      <= '0;
            ptr      <= '0;
            cnt      <= '0;
            stable   <= '0;
            one_shot <= '0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            stable   <= stable_nxt;
            one_shot <= one_shot_nxt;
        end
    end

    assign busy       = (state != S_IDLE);
    assign active_idx = idx;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: table vectors, hand-timed corner sequences and random bouncing
// checked every cycle against a grant-age reference model.
module tb_debounce_scheduler;

    localparam int N  = 4;
    localparam int D  = 10;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          nrst;
    logic [N-1:0]  sw;
    logic [N-1:0]  stable;
    logic [N-1:0]  one_shot;
    logic          busy;
    logic [IW-1:0] active_idx;

    int checks   = 0;
    int failures = 0;

    // Reference: sw delayed two edges, committed levels, and the age of the current grant.
    logic [N-1:0] m_s1, m_s2, m_stable, m_pulse;
    logic         m_busy;
    int           m_g, m_age, m_ptr;

    typedef struct {
        logic [N-1:0] sw;
        int           cycles;
        logic [N-1:0] exp_stable;
        int           exp_pulses;
        logic [N-1:0] exp_mask;
    } vec_t;

    vec_t vecs[6];

    debounce_scheduler #(.N(N), .DELAY_CYCLES(D)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .sw         (sw),
        .stable     (stable),
        .one_shot   (one_shot),
        .busy       (busy),
        .active_idx (active_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_stable = '0; m_pulse = '0;
        m_busy = 1'b0; m_g = 0; m_age = 0; m_ptr = 0;
    endtask

    task automatic model_edge();
        if (!nrst) begin
            model_reset();
        end else begin
            m_pulse = '0;
            if (m_busy) begin
                if (m_age < D) begin
                    if (m_s2[m_g] == m_stable[m_g]) begin
                        m_busy = 1'b0;
                        m_ptr  = (m_g + 1) % N;
                    end else begin
                        m_age++;
                    end
                end else begin
                    if (m_s2[m_g] != m_stable[m_g]) begin
                        m_stable[m_g] = m_s2[m_g];
                        m_pulse[m_g]  = m_s2[m_g];
                    end
                    m_busy = 1'b0;
                    m_ptr  = (m_g + 1) % N;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (!m_busy && (m_s2[(m_ptr + k) % N] != m_stable[(m_ptr + k) % N])) begin
                        m_g    = (m_ptr + k) % N;
                        m_age  = 0;
                        m_busy = 1'b1;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
    endtask

    task automatic cmp_model();
        checks++;
        if (stable !== m_stable || one_shot !== m_pulse || busy !== m_busy ||
            active_idx !== IW'(m_g)) begin
            failures++;
            $display("FAIL model at %0t: stable=%b/%b one_shot=%b/%b busy=%b/%b idx=%0d/%0d",
                     $time, stable, m_stable, one_shot, m_pulse, busy, m_busy, active_idx, m_g);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            cmp_model();
        end
    endtask

    // Steps n cycles, tallying pulse bits and capturing the first two pulse patterns.
    task automatic run_count(input int n, output int pulses, output int first_at,
                             output logic [N-1:0] first_mask, output logic [N-1:0] second_mask);
        pulses = 0; first_at = 0; first_mask = '0; second_mask = '0;
        for (int i = 1; i <= n; i++) begin
            step(1);
            if (one_shot != '0) begin
                if (first_at == 0) begin
                    first_at   = i;
                    first_mask = one_shot;
                end else if (second_mask == '0) begin
                    second_mask = one_shot;
                end
            end
            pulses += $countones(one_shot);
        end
    endtask

    task automatic reset_dut();
        sw = '0;
        #2 nrst = 1'b0;
        model_reset();
        step(2);
        #2 nrst = 1'b1;
        step(1);
    endtask

    initial begin
        int           p, p2, first;
        logic [N-1:0] m1, m2;
        logic [N-1:0] acc;

        sw   = '0;
        nrst = 1'b1;
        model_reset();
        #1 nrst = 1'b0;
        step(2);
        check("rst_stable", 32'(stable), 32'h0);
        check("rst_one_shot", 32'(one_shot), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_idx", 32'(active_idx), 32'h0);
        #2 nrst = 1'b1;
        step(1);

        // Single press: exact latency and busy window.
        sw = 4'b0001;
        step(2);
        check("press_busy_e1", 32'(busy), 32'h0);
        step(1);
        check("press_busy_e2", 32'(busy), 32'h1);
        step(10);
        check("press_busy_e12", 32'(busy), 32'h1);
        check("press_stable_e12", 32'(stable), 32'h0);
        step(1);
        check("press_stable_e13", 32'(stable), 32'h1);
        check("press_pulse_e13", 32'(one_shot), 32'h1);
        check("press_busy_e13", 32'(busy), 32'h0);
        step(1);
        check("press_pulse_e14", 32'(one_shot), 32'h0);

        reset_dut();
        vecs[0] = '{sw: 4'b0001, cycles: 20, exp_stable: 4'b0001, exp_pulses: 1, exp_mask: 4'b0001};
        vecs[1] = '{sw: 4'b0000, cycles: 20, exp_stable: 4'b0000, exp_pulses: 0, exp_mask: 4'b0000};
        vecs[2] = '{sw: 4'b1111, cycles: 60, exp_stable: 4'b1111, exp_pulses: 4, exp_mask: 4'b1111};
        vecs[3] = '{sw: 4'b1010, cycles: 40, exp_stable: 4'b1010, exp_pulses: 0, exp_mask: 4'b0000};
        vecs[4] = '{sw: 4'b0101, cycles: 60, exp_stable: 4'b0101, exp_pulses: 2, exp_mask: 4'b0101};
        vecs[5] = '{sw: 4'b0101, cycles: 5,  exp_stable: 4'b0101, exp_pulses: 0, exp_mask: 4'b0000};
        for (int v = 0; v < 6; v++) begin
            sw  = vecs[v].sw;
            acc = '0;
            p   = 0;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                step(1);
                acc |= one_shot;
                p   += $countones(one_shot);
            end
            check($sformatf("vec%0d_stable", v), 32'(stable), 32'(vecs[v].exp_stable));
            check($sformatf("vec%0d_pulses", v), 32'(p), 32'(vecs[v].exp_pulses));
            check($sformatf("vec%0d_mask", v), 32'(acc), 32'(vecs[v].exp_mask));
        end

        // Simultaneous rise: pulses 12 cycles apart starting at E0+13.
        reset_dut();
        sw = 4'b1111;
        run_count(14, p, first, m1, m2);
        check("simul_first_at", 32'(first), 32'd14);
        check("simul_first_mask", 32'(m1), 32'h1);
        run_count(12, p, first, m1, m2);
        check("simul_second_at", 32'(first), 32'd12);
        check("simul_second_mask", 32'(m1), 32'h2);

        // Fairness: after idx 2, idx 3 is served ahead of idx 1.
        reset_dut();
        sw = 4'b0100;
        step(20);
        sw = 4'b1110;
        run_count(40, p, first, m1, m2);
        check("fair_first", 32'(m1), 32'h8);
        check("fair_second", 32'(m2), 32'h2);
        check("fair_pulses", 32'(p), 32'd2);

        // Bounce on input 2 before it settles high.
        reset_dut();
        sw = 4'b0100;
        run_count(3, p, first, m1, m2);
        sw = 4'b0000;
        run_count(3, p2, first, m1, m2);
        check("bounce_quiet", 32'(p + p2), 32'd0);
        sw = 4'b0100;
        run_count(20, p, first, m1, m2);
        check("bounce_pulses", 32'(p), 32'd1);
        check("bounce_latency", 32'(first >= 1 && first <= 14), 32'd1);
        check("bounce_stable", 32'(stable), 32'h4);

        // Reset in the middle of a settle window.
        reset_dut();
        sw = 4'b0100;
        step(8);
        check("rmid_busy", 32'(busy), 32'h1);
        #2 nrst = 1'b0;
        model_reset();
        #1;
        check("rmid_async_clear", 32'({stable, one_shot, busy, active_idx}), 32'h0);
        step(2);
        #2 nrst = 1'b1;
        run_count(30, p, first, m1, m2);
        check("rmid_pulses", 32'(p), 32'd1);
        check("rmid_latency", 32'(first), 32'd14);

        // Random bouncing on all inputs, cross-checked every cycle.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 39) == 0) sw[b] = ~sw[b];
            end
            step(1);
        end
        step(60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
